// File: rtl/mcpu_debug_ctrl.sv
// Run-control and trace block for the multi-cycle CPU: halt/run/step/breakpoint
// gating of cpu_en, cycle/instruction counters and a show-ahead PC/IR trace FIFO.
module mcpu_debug_ctrl #(
  parameter int DATA_W        = 32,
  parameter int STATE_W       = 4,
  parameter int FETCH_STATE   = 0,
  parameter int CAPTURE_STATE = 1,
  parameter int DEPTH         = 16,
  parameter int CNT_W         = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  input  logic [1:0]                 cmd_i,
  input  logic                       bp_en_i,
  input  logic [DATA_W-1:0]          bp_addr_i,
  input  logic [DATA_W-1:0]          pc_i,
  input  logic [DATA_W-1:0]          ir_i,
  input  logic [STATE_W-1:0]         state_i,
  output logic                       cpu_en_o,
  output logic                       halted_o,
  output logic                       bp_hit_o,
  output logic [CNT_W-1:0]           cycle_cnt_o,
  output logic [CNT_W-1:0]           instr_cnt_o,
  input  logic                       trace_rd_i,
  output logic [DATA_W-1:0]          trace_pc_o,
  output logic [DATA_W-1:0]          trace_ir_o,
  output logic                       trace_empty_o,
  output logic                       trace_ovf_o,
  output logic [$clog2(DEPTH):0]     trace_level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] CMD_HALT = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_e;

  state_e            state_q, state_d;
  logic              skip_q, skip_d;
  logic              left_q, left_d;
  logic              bp_hit_q, bp_hit_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  logic [DATA_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] ir_mem [DEPTH];

  logic fetch, bp_match, capture, clear;
  logic empty, full, push, pop, push_ok;

  assign fetch    = (state_i == STATE_W'(FETCH_STATE));
  assign bp_match = bp_en_i & fetch & (pc_i == bp_addr_i) & ~skip_q;
  assign capture  = cpu_en_o & (state_i == STATE_W'(CAPTURE_STATE));

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    left_d   = left_q;
    bp_hit_d = bp_hit_q;
    clear    = 1'b0;
    cpu_en_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        cpu_en_o = ~bp_match;
        if (!fetch) skip_d = 1'b0;
        if (bp_match) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end
      end
      ST_STEP: begin
        cpu_en_o = ~(fetch & left_q);
        if (!fetch) left_d = 1'b1;
        if (fetch && left_q) state_d = ST_HALT;
      end
      default: ;
    endcase
    // Commands are applied last so they override breakpoint / step completion.
    if (cmd_valid_i) begin
      case (cmd_i)
        CMD_HALT: state_d = ST_HALT;
        CMD_RUN: begin
          if (state_q == ST_HALT) begin
            state_d  = ST_RUN;
            skip_d   = 1'b1;
            bp_hit_d = 1'b0;
          end
        end
        CMD_STEP: begin
          if (state_q == ST_HALT) begin
            state_d  = ST_STEP;
            left_d   = 1'b0;
            bp_hit_d = 1'b0;
          end
        end
        default: begin
          clear    = 1'b1;
          bp_hit_d = 1'b0;
        end
      endcase
    end
  end

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign push    = capture & ~clear;
  assign pop     = trace_rd_i & ~empty & ~clear;
  assign push_ok = push & (~full | pop);

  always_comb begin
    cycle_d  = cycle_q + CNT_W'(cpu_en_o);
    instr_d  = instr_q + CNT_W'(capture);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    ovf_d    = ovf_q | (push & full & ~pop);
    if (clear) begin
      cycle_d  = '0;
      instr_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_HALT;
      skip_q   <= 1'b0;
      left_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      ovf_q    <= 1'b0;
      cycle_q  <= '0;
      instr_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      left_q   <= left_d;
      bp_hit_q <= bp_hit_d;
      ovf_q    <= ovf_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // When full with a simultaneous pop, the new entry lands in the slot being vacated.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q] <= pc_i;
      ir_mem[wr_ptr_q] <= ir_i;
    end
  end

  assign halted_o      = (state_q == ST_HALT);
  assign bp_hit_o      = bp_hit_q;
  assign cycle_cnt_o   = cycle_q;
  assign instr_cnt_o   = instr_q;
  assign trace_empty_o = empty;
  assign trace_ovf_o   = ovf_q;
  assign trace_level_o = level_q;
  assign trace_pc_o    = empty ? '0 : pc_mem[rd_ptr_q];
  assign trace_ir_o    = empty ? '0 : ir_mem[rd_ptr_q];

endmodule
